// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// Each operation takes four cycles (IDLE, EXEC, CAPT, DONE) and returns a result and a flags snapshot to its port.
module alu_arbiter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic [4:0]  i_funSel0,
    input  logic [4:0]  i_funSel1,
    input  logic [15:0] i_a0,
    input  logic [15:0] i_b0,
    input  logic [15:0] i_a1,
    input  logic [15:0] i_b1,
    input  logic        i_wf0,
    input  logic        i_wf1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_done0,
    output logic        o_done1,
    output logic [15:0] o_result0,
    output logic [15:0] o_result1,
    output logic [3:0]  o_flags0,
    output logic [3:0]  o_flags1,
    output logic [15:0] o_aluA,
    output logic [15:0] o_aluB,
    output logic [4:0]  o_aluFunSel,
    output logic        o_aluWF,
    input  logic [15:0] i_aluOut,
    input  logic [3:0]  i_aluFlags
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CAPT,
        ST_DONE
    } state_t;

    state_t      r_state;
    logic        r_sel;
    logic        r_lastGnt;
    logic [4:0]  r_cmdFunSel;
    logic [15:0] r_cmdA;
    logic [15:0] r_cmdB;
    logic        r_aluWF;
    logic [15:0] r_resultReg;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic [15:0] r_result0;
    logic [15:0] r_result1;
    logic [3:0]  r_flags0;
    logic [3:0]  r_flags1;

    logic w_anyReq;
    logic w_pick;

    // Under contention the port that did not win last time goes next.
    assign w_anyReq = i_req0 | i_req1;
    assign w_pick   = (i_req0 & i_req1) ? ~r_lastGnt : i_req1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_lastGnt   <= 1'b1;
            r_cmdFunSel <= '0;
            r_cmdA      <= '0;
            r_cmdB      <= '0;
            r_aluWF     <= 1'b0;
            r_resultReg <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_result0   <= '0;
            r_result1   <= '0;
            r_flags0    <= '0;
            r_flags1    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_anyReq) begin
                        r_sel       <= w_pick;
                        r_cmdFunSel <= w_pick ? i_funSel1 : i_funSel0;
                        r_cmdA      <= w_pick ? i_a1 : i_a0;
                        r_cmdB      <= w_pick ? i_b1 : i_b0;
                        r_aluWF     <= w_pick ? i_wf1 : i_wf0;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_state     <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_resultReg <= i_aluOut;
                    r_lastGnt   <= r_sel;
                    r_aluWF     <= 1'b0;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_state     <= ST_CAPT;
                end
                ST_CAPT: begin
                    // The ALU flag register was written at the EXEC edge, so it is sampled one cycle later.
                    if (r_sel) begin
                        r_result1 <= r_resultReg;
                        r_flags1  <= i_aluFlags;
                        r_done1   <= 1'b1;
                    end else begin
                        r_result0 <= r_resultReg;
                        r_flags0  <= i_aluFlags;
                        r_done0   <= 1'b1;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt0      = r_gnt0;
    assign o_gnt1      = r_gnt1;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_result0   = r_result0;
    assign o_result1   = r_result1;
    assign o_flags0    = r_flags0;
    assign o_flags1    = r_flags1;
    assign o_aluA      = r_cmdA;
    assign o_aluB      = r_cmdB;
    assign o_aluFunSel = r_cmdFunSel;
    assign o_aluWF     = r_aluWF;

endmodule
